// File: rtl/mstr0_frame_pkg.sv
// Shared types, constants and word builders for the master-0 burst framer.
// No timing of its own; used by the framer FSM and its output register.
// Holds the header/trailer layout in one place so both stay in sync.
package mstr0_frame_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        TRAIL = 2'd2,
        WAIT  = 2'd3
    } state_t;

    localparam logic [1:0] KIND_HDR  = 2'b00;
    localparam logic [1:0] KIND_DATA = 2'b01;
    localparam logic [1:0] KIND_TRL  = 2'b10;

    localparam logic [7:0] HDR_MAGIC = 8'hA5;
    localparam logic [7:0] TRL_MAGIC = 8'h5A;

    localparam int HDR_MAGIC_LSB = 24;
    localparam int HDR_SEQ_LSB   = 16;
    localparam int HDR_MODE_LSB  = 14;
    localparam int HDR_SRC_BIT   = 13;
    localparam int TRL_MAGIC_LSB = 24;
    localparam int TRL_CNT_LSB   = 16;
    localparam int TRL_CHK_LSB   = 0;

    function automatic logic [31:0] hdr_word(input logic [7:0] seq,
                                             input logic [1:0] mode,
                                             input logic       src);
        logic [31:0] w;
        w = '0;
        w[HDR_MAGIC_LSB +: 8] = HDR_MAGIC;
        w[HDR_SEQ_LSB   +: 8] = seq;
        w[HDR_MODE_LSB  +: 2] = mode;
        w[HDR_SRC_BIT]        = src;
        return w;
    endfunction

    // Checksum is a running XOR folded to 16 bits at trailer time.
    function automatic logic [31:0] trl_word(input logic [7:0]  cnt,
                                             input logic [31:0] chk);
        logic [31:0] w;
        w = '0;
        w[TRL_MAGIC_LSB +: 8]  = TRL_MAGIC;
        w[TRL_CNT_LSB   +: 8]  = cnt;
        w[TRL_CHK_LSB   +: 16] = chk[31:16] ^ chk[15:0];
        return w;
    endfunction

endpackage

// File: rtl/mstr0_out_reg.sv
// Single-stage output holding register for the master-0 stream.
// Latency: a load appears on out_valid the next cycle.
// Backpressure: accepts a load only when empty or draining; holds contents while stalled.
module mstr0_out_reg #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld,
    input  logic [DW-1:0] ld_data,
    input  logic [1:0]    ld_kind,
    input  logic          ld_last,
    input  logic          out_ready,
    output logic          free,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic [1:0]    out_kind,
    output logic          out_last
);

    assign free = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_kind  <= 2'b00;
            out_last  <= 1'b0;
        end else if (free) begin
            out_valid <= ld;
            if (ld) begin
                out_data <= ld_data;
                out_kind <= ld_kind;
                out_last <= ld_last;
            end
        end
    end

endmodule

// File: rtl/mstr0_burst_framer.sv
// Frames master-0 FIFO words into header / data / trailer bursts with checksum.
// Latency: one cycle from FIFO pop (or header/trailer decision) to out_valid.
// Backpressure: pops only while the output register is free; stalls hold the register.
module mstr0_burst_framer
    import mstr0_frame_pkg::*;
#(
    parameter int DW        = 32,
    parameter int BURST_LEN = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_source,
    input  logic [1:0]    in_mode,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic [1:0]    out_kind,
    output logic          frame_done,
    output logic [15:0]   frame_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state;
    logic          src;
    logic [1:0]    mode;
    logic [7:0]    seq;
    logic [7:0]    count;
    logic [31:0]   chk;
    logic [TW-1:0] tmo;

    logic          free;
    logic          tag_ok;
    logic          xfer;
    logic          trl_acc;
    logic [7:0]    count_inc;
    logic [TW-1:0] tmo_inc;

    logic          ld;
    logic [DW-1:0] ld_data;
    logic [1:0]    ld_kind;
    logic          ld_last;

    assign tag_ok    = (in_source == src) && (in_mode == mode);
    assign in_ready  = (state == DATA) && free && tag_ok && (count < 8'(BURST_LEN));
    assign xfer      = in_valid && in_ready;
    assign trl_acc   = (state == WAIT) && out_valid && out_ready;
    assign count_inc = count + 8'd1;
    assign tmo_inc   = tmo + TW'(1);

    always_comb begin
        ld      = 1'b0;
        ld_data = '0;
        ld_kind = KIND_HDR;
        ld_last = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && free) begin
                    ld            = 1'b1;
                    ld_data[31:0] = hdr_word(seq, in_mode, in_source);
                end
            end
            DATA: begin
                if (xfer) begin
                    ld      = 1'b1;
                    ld_data = in_data;
                    ld_kind = KIND_DATA;
                end
            end
            TRAIL: begin
                if (free) begin
                    ld            = 1'b1;
                    ld_data[31:0] = trl_word(count, chk);
                    ld_kind       = KIND_TRL;
                    ld_last       = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            src        <= 1'b0;
            mode       <= 2'b00;
            seq        <= 8'd0;
            count      <= 8'd0;
            chk        <= 32'd0;
            tmo        <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= 16'd0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && free) begin
                        src   <= in_source;
                        mode  <= in_mode;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        count <= count_inc;
                        chk   <= chk ^ in_data[31:0];
                        tmo   <= '0;
                        if (count_inc == 8'(BURST_LEN))
                            state <= TRAIL;
                    end else if (in_valid && !tag_ok) begin
                        // Head word belongs to the next burst; leave it in the FIFO.
                        state <= TRAIL;
                    end else begin
                        tmo <= tmo_inc;
                        if (tmo_inc == TW'(TIMEOUT))
                            state <= TRAIL;
                    end
                end
                TRAIL: begin
                    if (free)
                        state <= WAIT;
                end
                WAIT: begin
                    if (trl_acc) begin
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 16'd1;
                        seq        <= seq + 8'd1;
                        count      <= 8'd0;
                        chk        <= 32'd0;
                        tmo        <= '0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    mstr0_out_reg #(.DW(DW)) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .ld        (ld),
        .ld_data   (ld_data),
        .ld_kind   (ld_kind),
        .ld_last   (ld_last),
        .out_ready (out_ready),
        .free      (free),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_kind  (out_kind),
        .out_last  (out_last)
    );

endmodule

// File: tb/tb_mstr0_burst_framer.sv
// Directed bench for mstr0_burst_framer with a queue-backed FIFO model and output monitor.
`timescale 1ns/1ps
module tb_mstr0_burst_framer;

    localparam int DW = 32;
    localparam int BL = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          in_source;
    logic [1:0]    in_mode;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [1:0]    out_kind;
    logic          frame_done;
    logic [15:0]   frame_cnt;

    typedef struct {
        logic       src;
        logic [1:0] mode;
        logic [31:0] data;
    } in_t;

    typedef struct {
        logic [1:0]  kind;
        logic        last;
        logic [31:0] data;
        int          cyc;
    } obs_t;

    in_t  fq[$];
    obs_t oq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int fd_cnt = 0;
    int stall_viol = 0;
    int rdy_viol = 0;
    int stall_seen = 0;

    always #5 clk = ~clk;

    mstr0_burst_framer #(.DW(DW), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_source  (in_source),
        .in_mode    (in_mode),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .out_kind   (out_kind),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    // Show-ahead FIFO model and downstream ready pattern, updated just after each edge.
    initial begin : feeder
        bit  popped;
        in_t dmy;
        in_data   = '0;
        in_valid  = 1'b0;
        in_source = 1'b0;
        in_mode   = 2'b00;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            popped = in_valid && in_ready && !rst;
            @(posedge clk);
            #1;
            cyc++;
            if (popped && fq.size() > 0) dmy = fq.pop_front();
            if (fq.size() > 0) begin
                in_valid  = 1'b1;
                in_source = fq[0].src;
                in_mode   = fq[0].mode;
                in_data   = fq[0].data;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
        end
    end

    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [1:0]  prev_kind;
    logic        prev_last;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!out_valid || out_data !== prev_data ||
                               out_kind !== prev_kind || out_last !== prev_last))
                stall_viol++;
            if (out_valid && !out_ready) stall_seen++;
            if (out_valid && !out_ready && in_ready) rdy_viol++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_kind  = out_kind;
            prev_last  = out_last;
            if (out_valid && out_ready)
                oq.push_back('{kind: out_kind, last: out_last, data: out_data, cyc: cyc});
            if (frame_done) fd_cnt++;
        end
    end

    task automatic push(input logic s, input logic [1:0] m, input logic [31:0] d);
        fq.push_back('{src: s, mode: m, data: d});
    endtask

    task automatic wait_words(input int n, input int budget);
        int k = 0;
        while (oq.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %h expected 0000", frame_cnt); end
        checks++;
        if ({frame_done, out_last, out_kind} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {frame_done, out_last, out_kind}); end
        checks++;
        if (out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data: got %h expected 00000000", out_data); end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if ({out_valid, in_ready} !== 2'b00) begin errors++; $display("FAIL reset_idle: got %b expected 00", {out_valid, in_ready}); end
    endtask

    task automatic test_full_burst();
        logic [34:0] exp [6];
        logic [34:0] got;
        exp = '{{2'b00, 1'b0, 32'hA5000000}, {2'b01, 1'b0, 32'h1}, {2'b01, 1'b0, 32'h2},
                {2'b01, 1'b0, 32'h3}, {2'b01, 1'b0, 32'h4}, {2'b10, 1'b1, 32'h5A040004}};
        oq.delete();
        fd_cnt = 0;
        for (int i = 1; i <= 4; i++) push(1'b0, 2'b00, 32'(i));
        wait_words(6, 60);
        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (oq.size() != 6) begin errors++; $display("FAIL full_burst_count: got %0d expected 6", oq.size()); end
        for (int i = 0; i < 6; i++) begin
            got = (i < oq.size()) ? {oq[i].kind, oq[i].last, oq[i].data} : 35'bx;
            checks++;
            if (got !== exp[i]) begin errors++; $display("FAIL full_burst_w%0d: got %h expected %h", i, got, exp[i]); end
        end
        checks++;
        if (fd_cnt != 1) begin errors++; $display("FAIL full_burst_done: got %0d pulses expected 1", fd_cnt); end
        checks++;
        if (frame_cnt !== 16'd1) begin errors++; $display("FAIL full_burst_frame_cnt: got %0d expected 1", frame_cnt); end
    endtask

    task automatic test_timeout();
        logic [34:0] exp [4];
        logic [34:0] got;
        exp = '{{2'b00, 1'b0, 32'hA5010000}, {2'b01, 1'b0, 32'h10},
                {2'b01, 1'b0, 32'h20}, {2'b10, 1'b1, 32'h5A020030}};
        oq.delete();
        push(1'b0, 2'b00, 32'h10);
        push(1'b0, 2'b00, 32'h20);
        wait_words(4, 80);
        repeat (3) @(posedge clk);
        #2;
        for (int i = 0; i < 4; i++) begin
            got = (i < oq.size()) ? {oq[i].kind, oq[i].last, oq[i].data} : 35'bx;
            checks++;
            if (got !== exp[i]) begin errors++; $display("FAIL timeout_w%0d: got %h expected %h", i, got, exp[i]); end
        end
        checks++;
        if (oq.size() < 4 || (oq[3].cyc - oq[2].cyc) != TO + 1) begin
            errors++;
            $display("FAIL timeout_gap: got %0d cycles expected %0d", (oq.size() < 4) ? -1 : oq[3].cyc - oq[2].cyc, TO + 1);
        end
        checks++;
        if (frame_cnt !== 16'd2) begin errors++; $display("FAIL timeout_frame_cnt: got %0d expected 2", frame_cnt); end
    endtask

    task automatic test_stall();
        logic [34:0] exp [6];
        logic [34:0] got;
        exp = '{{2'b00, 1'b0, 32'hA5020000}, {2'b01, 1'b0, 32'h11}, {2'b01, 1'b0, 32'h22},
                {2'b01, 1'b0, 32'h44}, {2'b01, 1'b0, 32'h88}, {2'b10, 1'b1, 32'h5A0400FF}};
        oq.delete();
        stall_viol = 0;
        rdy_viol   = 0;
        stall_seen = 0;
        rdy_mode   = 1;
        push(1'b0, 2'b00, 32'h11);
        push(1'b0, 2'b00, 32'h22);
        push(1'b0, 2'b00, 32'h44);
        push(1'b0, 2'b00, 32'h88);
        wait_words(6, 200);
        repeat (6) @(posedge clk);
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (oq.size() != 6) begin errors++; $display("FAIL stall_count: got %0d expected 6", oq.size()); end
        for (int i = 0; i < 6; i++) begin
            got = (i < oq.size()) ? {oq[i].kind, oq[i].last, oq[i].data} : 35'bx;
            checks++;
            if (got !== exp[i]) begin errors++; $display("FAIL stall_w%0d: got %h expected %h", i, got, exp[i]); end
        end
        checks++;
        if (stall_seen == 0) begin errors++; $display("FAIL stall_seen: got %0d stall cycles expected >0", stall_seen); end
        checks++;
        if (stall_viol != 0) begin errors++; $display("FAIL stall_hold: got %0d unstable cycles expected 0", stall_viol); end
        checks++;
        if (rdy_viol != 0) begin errors++; $display("FAIL stall_in_ready: got %0d pops while full expected 0", rdy_viol); end
        checks++;
        if (frame_cnt !== 16'd3) begin errors++; $display("FAIL stall_frame_cnt: got %0d expected 3", frame_cnt); end
    endtask

    task automatic test_tag_change();
        logic [34:0] exp [8];
        logic [34:0] got;
        exp = '{{2'b00, 1'b0, 32'hA503A000}, {2'b01, 1'b0, 32'hB1}, {2'b01, 1'b0, 32'hB2},
                {2'b10, 1'b1, 32'h5A020003}, {2'b00, 1'b0, 32'hA5040000}, {2'b01, 1'b0, 32'hC1},
                {2'b10, 1'b1, 32'h5A0100C1}, {2'b00, 1'b0, 32'h0}};
        oq.delete();
        push(1'b1, 2'b10, 32'hB1);
        push(1'b1, 2'b10, 32'hB2);
        push(1'b0, 2'b00, 32'hC1);
        wait_words(7, 120);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (oq.size() != 7) begin errors++; $display("FAIL tag_count: got %0d expected 7", oq.size()); end
        for (int i = 0; i < 7; i++) begin
            got = (i < oq.size()) ? {oq[i].kind, oq[i].last, oq[i].data} : 35'bx;
            checks++;
            if (got !== exp[i]) begin errors++; $display("FAIL tag_w%0d: got %h expected %h", i, got, exp[i]); end
        end
        checks++;
        if (frame_cnt !== 16'd5) begin errors++; $display("FAIL tag_frame_cnt: got %0d expected 5", frame_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [34:0] exp [3];
        logic [34:0] got;
        exp = '{{2'b00, 1'b0, 32'hA5000000}, {2'b01, 1'b0, 32'h77}, {2'b10, 1'b1, 32'h5A010077}};
        oq.delete();
        for (int i = 0; i < 4; i++) push(1'b0, 2'b00, 32'hE1 + 32'(i));
        wait_words(2, 40);
        @(posedge clk);
        #2;
        checks++;
        if ({out_valid, out_kind} !== 3'b101) begin errors++; $display("FAIL rstmid_pre: got %b expected 101", {out_valid, out_kind}); end
        fd_cnt = 0;
        rst = 1'b1;
        #1;
        fq.delete();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_frame_cnt: got %0d expected 0", frame_cnt); end
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (fd_cnt != 0 || out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_trailer: got %0d pulses valid %b expected 0 pulses valid 0", fd_cnt, out_valid); end
        oq.delete();
        push(1'b0, 2'b00, 32'h77);
        wait_words(3, 60);
        repeat (3) @(posedge clk);
        #2;
        for (int i = 0; i < 3; i++) begin
            got = (i < oq.size()) ? {oq[i].kind, oq[i].last, oq[i].data} : 35'bx;
            checks++;
            if (got !== exp[i]) begin errors++; $display("FAIL rstmid_w%0d: got %h expected %h", i, got, exp[i]); end
        end
        checks++;
        if (frame_cnt !== 16'd1) begin errors++; $display("FAIL rstmid_frame_cnt_after: got %0d expected 1", frame_cnt); end
    endtask

    task automatic test_back_to_back();
        int          bad = 0;
        logic [31:0] got;
        @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        oq.delete();
        fd_cnt = 0;
        for (int i = 0; i < 256 * BL; i++) push(1'b0, 2'b00, 32'(i));
        wait_words(256 * 6, 4000);
        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (oq.size() != 256 * 6) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", oq.size(), 256 * 6); end
        for (int k = 0; k < 256 && k * 6 < oq.size(); k++)
            if (oq[k * 6].data !== {8'hA5, 8'(k), 16'h0000} || oq[k * 6].kind !== 2'b00) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL b2b_headers: got %0d bad headers expected 0", bad); end
        got = (oq.size() > 255 * 6) ? oq[255 * 6].data : 32'hx;
        checks++;
        if (got !== 32'hA5FF0000) begin errors++; $display("FAIL b2b_seq_ff: got %h expected a5ff0000", got); end
        checks++;
        if (frame_cnt !== 16'd256) begin errors++; $display("FAIL b2b_frame_cnt: got %0d expected 256", frame_cnt); end
        checks++;
        if (fd_cnt != 256) begin errors++; $display("FAIL b2b_done: got %0d pulses expected 256", fd_cnt); end
        for (int i = 0; i < BL; i++) push(1'b0, 2'b00, 32'h100 + 32'(i));
        wait_words(257 * 6, 60);
        repeat (3) @(posedge clk);
        #2;
        got = (oq.size() > 256 * 6) ? oq[256 * 6].data : 32'hx;
        checks++;
        if (got !== 32'hA5000000) begin errors++; $display("FAIL b2b_seq_wrap: got %h expected a5000000", got); end
        checks++;
        if (frame_cnt !== 16'd257) begin errors++; $display("FAIL b2b_frame_cnt_after: got %0d expected 257", frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_full_burst();
        test_timeout();
        test_stall();
        test_tag_change();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
